// File: rtl/ldm_stm_sequencer.sv
// Purpose : LDM/STM block-transfer engine; walks a 16-bit register list, one word access per register.
// Latency : one cycle per acknowledged access, plus one writeback cycle (if enabled) and one Done cycle.
// Backpress: MemReq/MemAddr/MemWE/MemWD are held stable until MemAck; wait cycles are unbounded.
//
// Ports:
//   CLK, RSTn              clock, asynchronous active-low reset
//   Start..WriteBack       transfer request and its attributes, latched in IDLE on Start
//   RA / RD                register-file read port (store data source)
//   MemReq..MemRD, MemAck  word memory port (req/ack)
//   A3 / WD3 / WE3         register-file write port (loads and base writeback)
//   PCLoad / PCValue       PC load path, used when R15 is loaded
//   Busy / Done            status: Busy outside IDLE, Done one-cycle completion pulse
module ldm_stm_sequencer #(
  parameter int WORD_BYTES = 4,
  parameter int AW         = 32
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          Start,
  input  logic          IsLoad,
  input  logic [15:0]   RegList,
  input  logic [AW-1:0] BaseAddr,
  input  logic [3:0]    BaseReg,
  input  logic          Up,
  input  logic          Pre,
  input  logic          WriteBack,
  output logic [3:0]    RA,
  input  logic [AW-1:0] RD,
  output logic          MemReq,
  output logic          MemWE,
  output logic [AW-1:0] MemAddr,
  output logic [AW-1:0] MemWD,
  input  logic          MemAck,
  input  logic [AW-1:0] MemRD,
  output logic [3:0]    A3,
  output logic [AW-1:0] WD3,
  output logic          WE3,
  output logic          PCLoad,
  output logic [AW-1:0] PCValue,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WB     = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Transfer context, latched on Start
  logic          r_is_load;
  logic [15:0]   r_rem;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_fb;
  logic [3:0]    r_base_reg;
  logic          r_wb;
  logic          r_base_in_list;

  logic [4:0]    w_cnt;
  logic [AW-1:0] w_span;
  logic [AW-1:0] w_stride;
  logic [AW-1:0] w_addr0;
  logic [AW-1:0] w_fb;
  logic [3:0]    w_idx;
  logic [15:0]   w_rem_next;
  logic          w_start;
  logic          w_ack;
  logic          w_wb_en;

  assign w_stride = AW'(WORD_BYTES);
  assign w_span   = AW'(w_cnt) * w_stride;
  assign w_start  = (r_state == S_IDLE) && Start;
  assign w_ack    = (r_state == S_ACCESS) && MemAck;

  // Number of registers in the list
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      w_cnt = w_cnt + {4'd0, RegList[i]};
    end
  end

  // Lowest address of the block; registers always go out lowest index first at ascending
  // addresses, so a descending transfer starts at the bottom of the block.
  always_comb begin
    case ({Up, Pre})
      2'b10:   w_addr0 = BaseAddr;
      2'b11:   w_addr0 = BaseAddr + w_stride;
      2'b00:   w_addr0 = BaseAddr - w_span + w_stride;
      default: w_addr0 = BaseAddr - w_span;
    endcase
  end

  assign w_fb = Up ? (BaseAddr + w_span) : (BaseAddr - w_span);

  // Lowest set bit of the remaining mask (scan high to low so the lowest wins)
  always_comb begin
    w_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (r_rem[i]) w_idx = 4'(i);
    end
  end

  // Clears exactly the lowest set bit
  assign w_rem_next = r_rem & (r_rem - 16'd1);

  // Base writeback is skipped for R15, and for a load that also loads the base register
  assign w_wb_en = (r_base_reg != 4'd15) && !(r_is_load && r_base_in_list);

  // State register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start) w_state_nxt = (RegList != 16'd0) ? S_ACCESS : S_DONE;
      end
      S_ACCESS: begin
        if (MemAck && (w_rem_next == 16'd0)) w_state_nxt = r_wb ? S_WB : S_DONE;
      end
      S_WB:    w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Transfer context
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_is_load      <= 1'b0;
      r_rem          <= '0;
      r_addr         <= '0;
      r_fb           <= '0;
      r_base_reg     <= '0;
      r_wb           <= 1'b0;
      r_base_in_list <= 1'b0;
    end else if (w_start) begin
      r_is_load      <= IsLoad;
      r_rem          <= RegList;
      r_addr         <= w_addr0;
      r_fb           <= w_fb;
      r_base_reg     <= BaseReg;
      r_wb           <= WriteBack;
      r_base_in_list <= RegList[BaseReg];
    end else if (w_ack) begin
      r_rem  <= w_rem_next;
      r_addr <= r_addr + w_stride;
    end
  end

  // Outputs: all zero unless the current state drives them
  always_comb begin
    RA      = '0;
    MemReq  = 1'b0;
    MemWE   = 1'b0;
    MemAddr = '0;
    MemWD   = '0;
    A3      = '0;
    WD3     = '0;
    WE3     = 1'b0;
    PCLoad  = 1'b0;
    PCValue = '0;
    Done    = 1'b0;
    Busy    = (r_state != S_IDLE);
    case (r_state)
      S_ACCESS: begin
        RA      = w_idx;
        MemReq  = 1'b1;
        MemWE   = !r_is_load;
        MemAddr = r_addr;
        MemWD   = RD;
        if (MemAck && r_is_load) begin
          if (w_idx == 4'd15) begin
            PCLoad  = 1'b1;
            PCValue = MemRD;
          end else begin
            WE3 = 1'b1;
            A3  = w_idx;
            WD3 = MemRD;
          end
        end
      end
      S_WB: begin
        if (w_wb_en) begin
          WE3 = 1'b1;
          A3  = r_base_reg;
          WD3 = r_fb;
        end
      end
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
module tb_ldm_stm_sequencer;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        Start;
  logic        IsLoad;
  logic [15:0] RegList;
  logic [31:0] BaseAddr;
  logic [3:0]  BaseReg;
  logic        Up;
  logic        Pre;
  logic        WriteBack;
  logic [3:0]  RA;
  logic [31:0] RD;
  logic        MemReq;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [31:0] MemWD;
  logic        MemAck;
  logic [31:0] MemRD;
  logic [3:0]  A3;
  logic [31:0] WD3;
  logic        WE3;
  logic        PCLoad;
  logic [31:0] PCValue;
  logic        Busy;
  logic        Done;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // Register file read model: Rn holds 0xC0DE000n
  assign RD = 32'hC0DE_0000 + {28'd0, RA};

  ldm_stm_sequencer #(.WORD_BYTES(4), .AW(32)) dut (
    .CLK(CLK), .RSTn(RSTn), .Start(Start), .IsLoad(IsLoad), .RegList(RegList),
    .BaseAddr(BaseAddr), .BaseReg(BaseReg), .Up(Up), .Pre(Pre), .WriteBack(WriteBack),
    .RA(RA), .RD(RD), .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWD(MemWD),
    .MemAck(MemAck), .MemRD(MemRD), .A3(A3), .WD3(WD3), .WE3(WE3), .PCLoad(PCLoad),
    .PCValue(PCValue), .Busy(Busy), .Done(Done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " Busy"},    {31'd0, Busy},    32'd0);
    chk({tag, " MemReq"},  {31'd0, MemReq},  32'd0);
    chk({tag, " MemWE"},   {31'd0, MemWE},   32'd0);
    chk({tag, " WE3"},     {31'd0, WE3},     32'd0);
    chk({tag, " PCLoad"},  {31'd0, PCLoad},  32'd0);
    chk({tag, " Done"},    {31'd0, Done},    32'd0);
    chk({tag, " RA"},      {28'd0, RA},      32'd0);
    chk({tag, " A3"},      {28'd0, A3},      32'd0);
    chk({tag, " WD3"},     WD3,              32'd0);
    chk({tag, " MemAddr"}, MemAddr,          32'd0);
    chk({tag, " MemWD"},   MemWD,            32'd0);
    chk({tag, " PCValue"}, PCValue,          32'd0);
  endtask

  task automatic setup(input logic ld, input logic [15:0] lst, input logic [31:0] base,
                       input logic [3:0] breg, input logic up, input logic pre, input logic wb);
    Start     = 1'b1;
    IsLoad    = ld;
    RegList   = lst;
    BaseAddr  = base;
    BaseReg   = breg;
    Up        = up;
    Pre       = pre;
    WriteBack = wb;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTn = 1'b0; Start = 1'b0; IsLoad = 1'b0; RegList = '0; BaseAddr = '0; BaseReg = '0;
    Up = 1'b0; Pre = 1'b0; WriteBack = 1'b0; MemAck = 1'b0; MemRD = '0;

    // Reset state
    #12;
    chk_all_zero("reset");
    RSTn = 1'b1;
    tick();

    // MemAck in IDLE is ignored
    MemAck = 1'b1;
    #1;
    chk("idle_ack MemReq", {31'd0, MemReq}, 32'd0);
    chk("idle_ack WE3",    {31'd0, WE3},    32'd0);

    // LDM, Up, post-index, writeback: R1..R3 from 0x100
    setup(1'b1, 16'h000E, 32'h100, 4'd0, 1'b1, 1'b0, 1'b1);
    tick();
    Start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      MemRD = 32'hA1 + k;
      #1;
      chk("ldm Busy",    {31'd0, Busy},   32'd1);
      chk("ldm MemReq",  {31'd0, MemReq}, 32'd1);
      chk("ldm MemWE",   {31'd0, MemWE},  32'd0);
      chk("ldm MemAddr", MemAddr,         32'h100 + 4 * k);
      chk("ldm WE3",     {31'd0, WE3},    32'd1);
      chk("ldm A3",      {28'd0, A3},     32'(k + 1));
      chk("ldm WD3",     WD3,             32'hA1 + k);
      tick();
    end
    chk("ldm wb WE3",    {31'd0, WE3},    32'd1);
    chk("ldm wb A3",     {28'd0, A3},     32'd0);
    chk("ldm wb WD3",    WD3,             32'h10C);
    chk("ldm wb MemReq", {31'd0, MemReq}, 32'd0);
    chk("ldm wb Done",   {31'd0, Done},   32'd0);
    tick();
    chk("ldm Done",      {31'd0, Done},   32'd1);
    chk("ldm done Busy", {31'd0, Busy},   32'd1);
    chk("ldm done WE3",  {31'd0, WE3},    32'd0);
    tick();
    chk("ldm idle Busy", {31'd0, Busy},   32'd0);
    chk("ldm idle Done", {31'd0, Done},   32'd0);

    // STM, Down, pre-index, writeback: R4 @0x1F8, R14 @0x1FC, base 0x1F8
    setup(1'b0, 16'h4010, 32'h200, 4'd2, 1'b0, 1'b1, 1'b1);
    tick();
    Start = 1'b0;
    #1;
    chk("stm1 RA",      {28'd0, RA},    32'd4);
    chk("stm1 MemWE",   {31'd0, MemWE}, 32'd1);
    chk("stm1 MemAddr", MemAddr,        32'h1F8);
    chk("stm1 MemWD",   MemWD,          32'hC0DE_0004);
    chk("stm1 WE3",     {31'd0, WE3},   32'd0);
    tick();
    chk("stm2 RA",      {28'd0, RA},    32'd14);
    chk("stm2 MemAddr", MemAddr,        32'h1FC);
    chk("stm2 MemWD",   MemWD,          32'hC0DE_000E);
    tick();
    chk("stm wb WE3",   {31'd0, WE3},   32'd1);
    chk("stm wb A3",    {28'd0, A3},    32'd2);
    chk("stm wb WD3",   WD3,            32'h1F8);
    tick();
    chk("stm Done",     {31'd0, Done},  32'd1);
    tick();

    // Wait states: LDM R0,R1, Up, pre-index, no writeback; ack after 3 wait cycles
    MemAck = 1'b0;
    setup(1'b1, 16'h0003, 32'h300, 4'd5, 1'b1, 1'b1, 1'b0);
    tick();
    for (int a = 0; a < 2; a++) begin
      for (int w = 0; w < 3; w++) begin
        Start = (w == 1);  // Start outside IDLE must be ignored
        #1;
        chk("wait MemReq",  {31'd0, MemReq}, 32'd1);
        chk("wait MemAddr", MemAddr,         32'h304 + 4 * a);
        chk("wait MemWE",   {31'd0, MemWE},  32'd0);
        chk("wait WE3",     {31'd0, WE3},    32'd0);
        tick();
      end
      Start  = 1'b0;
      MemAck = 1'b1;
      MemRD  = 32'h70 + a;
      #1;
      chk("wait ack WE3", {31'd0, WE3}, 32'd1);
      chk("wait ack A3",  {28'd0, A3},  32'(a));
      chk("wait ack WD3", WD3,          32'h70 + a);
      tick();
      MemAck = 1'b0;
    end
    #1;
    chk("wait Done",     {31'd0, Done}, 32'd1);
    chk("wait done WE3", {31'd0, WE3},  32'd0);
    tick();
    chk("wait idle Busy", {31'd0, Busy}, 32'd0);

    // R15 and base register in the list: R1 loaded, PC loaded, no writeback
    MemAck = 1'b1;
    setup(1'b1, 16'h8002, 32'h400, 4'd1, 1'b1, 1'b0, 1'b1);
    tick();
    Start = 1'b0;
    MemRD = 32'h55;
    #1;
    chk("r15 a1 WE3",     {31'd0, WE3},    32'd1);
    chk("r15 a1 A3",      {28'd0, A3},     32'd1);
    chk("r15 a1 WD3",     WD3,             32'h55);
    chk("r15 a1 PCLoad",  {31'd0, PCLoad}, 32'd0);
    chk("r15 a1 MemAddr", MemAddr,         32'h400);
    tick();
    MemRD = 32'h4000;
    #1;
    chk("r15 a2 WE3",     {31'd0, WE3},    32'd0);
    chk("r15 a2 PCLoad",  {31'd0, PCLoad}, 32'd1);
    chk("r15 a2 PCValue", PCValue,         32'h4000);
    chk("r15 a2 MemAddr", MemAddr,         32'h404);
    tick();
    chk("r15 wb WE3",     {31'd0, WE3},    32'd0);
    chk("r15 wb PCLoad",  {31'd0, PCLoad}, 32'd0);
    chk("r15 wb Busy",    {31'd0, Busy},   32'd1);
    chk("r15 wb Done",    {31'd0, Done},   32'd0);
    tick();
    chk("r15 Done",       {31'd0, Done},   32'd1);
    tick();

    // Empty list: no access, Done one cycle after Start
    setup(1'b1, 16'h0000, 32'h500, 4'd3, 1'b1, 1'b0, 1'b1);
    tick();
    Start = 1'b0;
    chk("empty Done",   {31'd0, Done},   32'd1);
    chk("empty MemReq", {31'd0, MemReq}, 32'd0);
    chk("empty WE3",    {31'd0, WE3},    32'd0);
    tick();
    chk("empty idle Busy", {31'd0, Busy}, 32'd0);

    // Reset during the second access of a 4-register LDM
    MemRD = 32'h11;
    setup(1'b1, 16'h000F, 32'h500, 4'd6, 1'b1, 1'b0, 1'b1);
    tick();
    Start = 1'b0;
    tick();
    chk("rst pre MemAddr", MemAddr, 32'h504);
    #1;
    RSTn = 1'b0;
    #1;
    chk_all_zero("rst mid");
    tick();
    RSTn   = 1'b1;
    MemAck = 1'b0;
    #1;
    chk("rst after Busy", {31'd0, Busy}, 32'd0);
    setup(1'b1, 16'h0001, 32'h600, 4'd7, 1'b1, 1'b0, 1'b0);
    tick();
    Start = 1'b0;
    chk("rst new MemReq",  {31'd0, MemReq}, 32'd1);
    chk("rst new MemAddr", MemAddr,         32'h600);
    MemAck = 1'b1;
    MemRD  = 32'h99;
    #1;
    chk("rst new WE3", {31'd0, WE3}, 32'd1);
    chk("rst new A3",  {28'd0, A3},  32'd0);
    chk("rst new WD3", WD3,          32'h99);
    tick();
    MemAck = 1'b0;
    chk("rst new Done", {31'd0, Done}, 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
